// File: rtl/fifo_read_scheduler_pkg.sv
// Shared types and helpers for the frame read scheduler: state encoding,
// serializer throughput and the per-word XMIT hold length.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_XMIT,
    S_GAP,
    S_FLUSH
  } sched_state_t;

  localparam int SER_BITS_PER_CYC = 16;
  localparam int HOLD_W           = 13;

  // max(1, ceil(bits / SER_BITS_PER_CYC)); 0xFFFF bits gives 4096, which fits HOLD_W.
  function automatic logic [HOLD_W-1:0] hold_len(input logic [15:0] data_count);
    logic [16:0]       bits_up;
    logic [HOLD_W-1:0] cycles;
    bits_up = {1'b0, data_count} + 17'(SER_BITS_PER_CYC - 1);
    cycles  = HOLD_W'(bits_up / 17'(SER_BITS_PER_CYC));
    return (cycles == '0) ? HOLD_W'(1) : cycles;
  endfunction

endpackage

// File: rtl/fifo_read_scheduler_if.sv
// Handshake bundle between the frame FIFO/serializer side and the read scheduler.
interface fifo_read_scheduler_if;

  logic        enable;
  logic        flush;
  logic        fifo_empty;
  logic [15:0] data_count;
  logic        fifo_r_enable;
  logic        word_start;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  modport master (
    output enable, flush, fifo_empty, data_count,
    input  fifo_r_enable, word_start, busy, frame_cnt, drop_cnt
  );

  modport slave (
    input  enable, flush, fifo_empty, data_count,
    output fifo_r_enable, word_start, busy, frame_cnt, drop_cnt
  );

endinterface

// File: rtl/fifo_read_scheduler_timer.sv
// Loadable down-counter shared by the LAT, XMIT and GAP states.
// done is high while the count is zero, i.e. on the last cycle of a timed state.
module frame_hold_timer
  import frame_sched_pkg::*;
(
  input  logic              clk_out,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HOLD_W-1:0] value,
  output logic              done
);

  logic [HOLD_W-1:0] count;

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - HOLD_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/fifo_read_scheduler.sv
// Paces single-cycle reads from the frame FIFO, pulses word_start after the read
// latency, holds off until the payload is shifted, and drains the FIFO on flush.
module fifo_read_scheduler
  import frame_sched_pkg::*;
#(
  parameter int READ_LAT   = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic            clk_out,
  input  logic            rst_n,
  fifo_read_scheduler_if.slave bus
);

  sched_state_t      state;
  sched_state_t      next_state;
  logic              load;
  logic [HOLD_W-1:0] load_value;
  logic              timer_done;
  logic [HOLD_W-1:0] hold_now;
  logic              flush_rd;
  logic              word_start_q;
  logic              busy_q;
  logic [15:0]       frame_cnt_q;
  logic [15:0]       drop_cnt_q;

  assign hold_now = hold_len(bus.data_count);
  assign flush_rd = (state == S_FLUSH) && !bus.fifo_empty;

  frame_hold_timer u_timer (
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .load    (load),
    .value   (load_value),
    .done    (timer_done)
  );

  // Timed states load "remaining cycles after this one" so done marks the last cycle.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_value = '0;
    unique case (state)
      S_IDLE: begin
        if (bus.flush && !bus.fifo_empty) begin
          next_state = S_FLUSH;
        end else if (bus.enable && !bus.fifo_empty) begin
          next_state = S_RD;
        end
      end
      S_RD: begin
        if (READ_LAT > 1) begin
          next_state = S_LAT;
          load       = 1'b1;
          load_value = HOLD_W'(READ_LAT - 2);
        end else begin
          next_state = S_XMIT;
        end
      end
      S_LAT: begin
        if (timer_done) next_state = S_XMIT;
      end
      S_XMIT: begin
        // data_count is only valid on the first XMIT cycle, so the hold is loaded here.
        if (word_start_q && (hold_now > HOLD_W'(1))) begin
          load       = 1'b1;
          load_value = hold_now - HOLD_W'(2);
        end else if (word_start_q || timer_done) begin
          if (GAP_CYCLES > 0) begin
            next_state = S_GAP;
            load       = 1'b1;
            load_value = HOLD_W'(GAP_CYCLES - 1);
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (timer_done) next_state = S_IDLE;
      end
      S_FLUSH: begin
        if (!bus.flush || bus.fifo_empty) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_out) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      word_start_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state        <= next_state;
      word_start_q <= (next_state == S_XMIT) && (state != S_XMIT);
      busy_q       <= (next_state != S_IDLE);
      if (word_start_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (flush_rd)     drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.fifo_r_enable = (state == S_RD) || flush_rd;
  assign bus.word_start    = word_start_q;
  assign bus.busy          = busy_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Bench for fifo_read_scheduler: two instances (default timing and READ_LAT=3/GAP=0)
// each fed by a behavioural FIFO; frame timing is predicted from the frame-period rule.
module tb_fifo_read_scheduler;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  fifo_read_scheduler_if bus0 ();
  fifo_read_scheduler_if bus1 ();

  fifo_read_scheduler u_dut0 (
    .clk_out (clk),
    .rst_n   (rst_n),
    .bus     (bus0)
  );

  fifo_read_scheduler #(.READ_LAT(3), .GAP_CYCLES(0)) u_dut1 (
    .clk_out (clk),
    .rst_n   (rst_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: a read at an edge presents its word READ_LAT edges later.
  logic [15:0] mem [2][256];
  int          wp [2];
  int          rp [2];
  logic [15:0] dl [2][4];

  initial begin
    wp[0] = 0;
    wp[1] = 0;
  end

  always @(posedge clk) begin
    if (cyc == 0) begin
      rp[0] <= 0;
      rp[1] <= 0;
    end else begin
      if (bus0.fifo_r_enable) begin
        dl[0][0] <= mem[0][rp[0] % 256];
        rp[0]    <= rp[0] + 1;
      end
      if (bus1.fifo_r_enable) begin
        dl[1][0] <= mem[1][rp[1] % 256];
        rp[1]    <= rp[1] + 1;
      end
    end
    for (int i = 1; i < 4; i++) begin
      dl[0][i] <= dl[0][i-1];
      dl[1][i] <= dl[1][i-1];
    end
  end

  assign bus0.fifo_empty = (wp[0] == rp[0]);
  assign bus1.fifo_empty = (wp[1] == rp[1]);
  assign bus0.data_count = dl[0][0];
  assign bus1.data_count = dl[1][2];

  // Event log sampled on the falling edge.
  int rd_t0[$];
  int rd_t1[$];
  int ws_t0[$];
  int ws_t1[$];
  int busy_n0;
  int busy_n1;

  initial begin
    busy_n0 = 0;
    busy_n1 = 0;
  end

  always @(negedge clk) begin
    if (bus0.fifo_r_enable === 1'b1) rd_t0.push_back(cyc);
    if (bus1.fifo_r_enable === 1'b1) rd_t1.push_back(cyc);
    if (bus0.word_start === 1'b1)    ws_t0.push_back(cyc);
    if (bus1.word_start === 1'b1)    ws_t1.push_back(cyc);
    if (bus0.busy === 1'b1)          busy_n0 = busy_n0 + 1;
    if (bus1.busy === 1'b1)          busy_n1 = busy_n1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int g, input logic [15:0] v);
    mem[g][wp[g] % 256] = v;
    wp[g] = wp[g] + 1;
  endtask

  function automatic int hold_ref(input int dc);
    int h;
    h = (dc + 15) / 16;
    return (h < 1) ? 1 : h;
  endfunction

  function automatic int ws_at(input int g, input int idx);
    if (g == 0) return (idx < ws_t0.size()) ? ws_t0[idx] : -1;
    return (idx < ws_t1.size()) ? ws_t1[idx] : -1;
  endfunction

  function automatic int rd_at(input int g, input int idx);
    if (g == 0) return (idx < rd_t0.size()) ? rd_t0[idx] : -1;
    return (idx < rd_t1.size()) ? rd_t1[idx] : -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd0"},   {31'd0, bus0.fifo_r_enable}, 32'd0);
    check({tag, "_ws0"},   {31'd0, bus0.word_start},    32'd0);
    check({tag, "_busy0"}, {31'd0, bus0.busy},          32'd0);
    check({tag, "_fc0"},   {16'd0, bus0.frame_cnt},     32'd0);
    check({tag, "_dc0"},   {16'd0, bus0.drop_cnt},      32'd0);
    check({tag, "_rd1"},   {31'd0, bus1.fifo_r_enable}, 32'd0);
    check({tag, "_ws1"},   {31'd0, bus1.word_start},    32'd0);
    check({tag, "_busy1"}, {31'd0, bus1.busy},          32'd0);
    check({tag, "_fc1"},   {16'd0, bus1.frame_cnt},     32'd0);
    check({tag, "_dc1"},   {16'd0, bus1.drop_cnt},      32'd0);
  endtask

  // Queue every word in dcs at once and predict each word_start from the frame period.
  int dcs[$];

  task automatic run_frames(input int g, input string tag);
    int t;
    int nxt;
    int lat;
    int gap;
    int s;
    int got;
    int expt[$];
    lat = (g == 0) ? 1 : 3;
    gap = (g == 0) ? 2 : 0;
    s   = (g == 0) ? ws_t0.size() : ws_t1.size();
    foreach (dcs[i]) push(g, 16'(dcs[i]));
    t   = cyc;
    nxt = t + 1 + lat;
    foreach (dcs[i]) begin
      expt.push_back(nxt);
      nxt = nxt + hold_ref(dcs[i]) + gap + 1 + lat;
    end
    step(nxt - t + 2);
    foreach (expt[i]) check({tag, "_ws_time"}, ws_at(g, s + i), expt[i]);
    got = ((g == 0) ? ws_t0.size() : ws_t1.size()) - s;
    check({tag, "_ws_count"}, got, dcs.size());
  endtask

  initial begin
    int t;
    int w;
    int s_rd;
    int s_ws;
    int b0;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus0.enable = 1'b0;
    bus0.flush  = 1'b0;
    bus1.enable = 1'b0;
    bus1.flush  = 1'b0;
    step(3);
    check_idle_outputs("reset");

    rst_n = 1'b1;
    step(2);

    // Single word, default timing.
    s_rd = rd_t0.size();
    s_ws = ws_t0.size();
    b0   = busy_n0;
    push(0, 16'd16);
    bus0.enable = 1'b1;
    t = cyc;
    step(12);
    check("single_rd_count", rd_t0.size() - s_rd, 1);
    check("single_rd_time",  rd_at(0, s_rd), t + 1);
    check("single_ws_time",  ws_at(0, s_ws), t + 2);
    check("single_busy_len", busy_n0 - b0, 4);
    check("single_frame_cnt", {16'd0, bus0.frame_cnt}, 1);

    // Three queued words: separations 5 and 7.
    dcs = '{16, 40, 0};
    run_frames(0, "three");
    check("three_frame_cnt", {16'd0, bus0.frame_cnt}, 4);

    // Random payload sizes on the default instance.
    dcs.delete();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) dcs.push_back(int'($urandom_range(0, 16)));
      else                           dcs.push_back(int'($urandom_range(17, 300)));
    end
    run_frames(0, "rand0");
    check("rand0_frame_cnt", {16'd0, bus0.frame_cnt}, 12);

    // Random payload sizes on the READ_LAT=3 / GAP=0 instance.
    bus1.enable = 1'b1;
    dcs.delete();
    for (int i = 0; i < 4; i++) dcs.push_back(int'($urandom_range(0, 200)));
    run_frames(1, "rand1");
    check("rand1_frame_cnt", {16'd0, bus1.frame_cnt}, 4);

    // Maximum payload: 4096-cycle XMIT, word_start three cycles after the read.
    s_rd = rd_t1.size();
    s_ws = ws_t1.size();
    b0   = busy_n1;
    push(1, 16'hFFFF);
    t = cyc;
    step(4110);
    check("max_rd_time",   rd_at(1, s_rd), t + 1);
    check("max_ws_time",   ws_at(1, s_ws), t + 4);
    check("max_busy_len",  busy_n1 - b0, 1 + 2 + 4096);
    check("max_busy_end",  {31'd0, bus1.busy}, 0);
    check("max_frame_cnt", {16'd0, bus1.frame_cnt}, 5);

    // Flush five queued words with enable low.
    bus0.enable = 1'b0;
    bus0.flush  = 1'b1;
    step(1);
    s_rd = rd_t0.size();
    s_ws = ws_t0.size();
    for (int i = 0; i < 5; i++) push(0, 16'($urandom_range(0, 500)));
    t = cyc;
    step(10);
    check("flush_rd_count", rd_t0.size() - s_rd, 5);
    for (int k = 0; k < 5; k++) check("flush_rd_time", rd_at(0, s_rd + k), t + 1 + k);
    check("flush_drop_cnt", {16'd0, bus0.drop_cnt}, 5);
    check("flush_no_ws",    ws_t0.size() - s_ws, 0);
    check("flush_idle",     {31'd0, bus0.busy}, 0);
    bus0.flush = 1'b0;

    // Flush and enable raised mid-XMIT: the frame completes, then FLUSH from IDLE.
    bus0.enable = 1'b1;
    step(1);
    s_rd = rd_t0.size();
    s_ws = ws_t0.size();
    push(0, 16'd64);
    push(0, 16'd16);
    push(0, 16'd16);
    t = cyc;
    w = t + 2;
    step(3);
    bus0.flush = 1'b1;
    step(15);
    check("midx_rd_count", rd_t0.size() - s_rd, 3);
    check("midx_rd_frame", rd_at(0, s_rd),     t + 1);
    check("midx_rd_drop1", rd_at(0, s_rd + 1), w + 7);
    check("midx_rd_drop2", rd_at(0, s_rd + 2), w + 8);
    check("midx_ws_count", ws_t0.size() - s_ws, 1);
    check("midx_frame_cnt", {16'd0, bus0.frame_cnt}, 13);
    check("midx_drop_cnt",  {16'd0, bus0.drop_cnt}, 7);
    bus0.flush  = 1'b0;
    bus0.enable = 1'b0;

    // Reset in the middle of a long XMIT, then a fresh frame.
    push(1, 16'hFFFF);
    step(15);
    check("prereset_busy", {31'd0, bus1.busy}, 1);
    rst_n = 1'b0;
    step(1);
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    step(2);
    s_ws = ws_t1.size();
    push(1, 16'd16);
    t = cyc;
    step(8);
    check("rst_new_ws_time", ws_at(1, s_ws), t + 4);
    check("rst_frame_cnt",   {16'd0, bus1.frame_cnt}, 1);
    check("rst_busy_end",    {31'd0, bus1.busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
